word_byte_sequencer: RTL

WORD_BYTE_SEQUENCER -- requirements
Module: word_byte_sequencer

---
 rtl/word_byte_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/word_byte_sequencer.sv
// word_byte_sequencer
//   Accepts a 32-bit word with a byte count. It then emits the enabled
//   bytes one at a time over a valid/ready byte stream. The emission order
//   is either LSB-first or MSB-first.
//
// Parameters
//   MSB_FIRST   0: byte 0 first, 1: highest enabled byte (word_len) first
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   word_in     word to serialize, byte k = word_in[8k+7:8k]
//   word_len    bytes to emit minus 1, captured together with word_in
//   word_valid  upstream offers word_in/word_len
//   word_ready  block can accept a word (high only in IDLE)
//   byte_out    current byte of the held word (0x00 when idle)
//   byte_valid  byte_out is valid (high only in SEND)
//   byte_ready  downstream accepts byte_out
//   byte_last   byte_out is the final byte of the held word
//   busy        a word is being held
module word_byte_sequencer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_in,
    input  logic [1:0]  word_len,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        byte_last
  , output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_word;
    logic [1:0]  r_len;
    logic [1:0]  r_sel;
    logic        w_load;
    logic        w_advance;
    logic        w_last;

    // The final byte is the one at the far end of the walk direction.
    assign w_last = MSB_FIRST ? (r_sel == 2'd0) : (r_sel == r_len);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        word_ready   = 1'b0;
        byte_valid   = 1'b0;
        byte_last    = 1'b0;
        busy         = 1'b0;
        byte_out     = '0;
        case (r_state)
            IDLE: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    w_load       = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                byte_valid = 1'b1;
                busy       = 1'b1;
                byte_last  = w_last;
                byte_out   = r_word[{r_sel, 3'b000} +: 8];
                // The handshake is checked only here. The last transfer
                // therefore returns the block to IDLE, and no word can be
                // accepted until the next edge. This gives one idle cycle
                // between words.
                if (byte_ready) begin
                    if (w_last) begin
                        w_state_next = IDLE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_len  <= '0;
            r_sel  <= '0;
        end else if (w_load) begin
            r_word <= word_in;
            r_len  <= word_len;
            r_sel  <= MSB_FIRST ? word_len : 2'd0;
        end else if (w_advance) begin
            r_sel  <= MSB_FIRST ? (r_sel - 2'd1) : (r_sel + 2'd1);
        end
    end

endmodule
